seg7_scan_ctrl: RTL and testbench
=================================

# seg7_scan_ctrl

Refresh scheduler for the multiplexed 7-segment display behind the AXI-Lite 7-seg LED peripheral. It takes the per-digit register values and global controls from the register slice and time-shares the common segment bus between digits. It drives active-low anodes, segments and decimal point with anti-ghost blanking and PWM brightness. New register contents are double-buffered and take effect only at a frame boundary, so a frame never shows a mix of old and new digits.

## Interface
- NUM_DIGITS, 4, number of multiplexed digits (2..8)
- DIGIT_TICKS, 100016, ACLK cycles per digit slot (blank phase plus on phase)
- BLANK_TICKS, 16, cycles at the start of each slot with all anodes off; (DIGIT_TICKS-BLANK_TICKS) must be a nonzero multiple of 16
- ACLK  in  1  clock
- ARESET  in  1  asynchronous, active-high reset
- digit_data  in  8*NUM_DIGITS  byte k drives digit k; bit 7 is the decimal point, bits 6:0 are as described under Configuration
- digit_en  in  NUM_DIGITS  per-digit enable mask
- brightness  in  4  on-phase duty in sixteenths; the anode is on for (brightness+1)/16 of the on phase
- update_req  in  1  pulse that requests loading the inputs above into the shadow registers
- update_ack  out  1  one-cycle pulse marking the cycle the shadow load happens
- frame_tick  out  1  one-cycle pulse in the last cycle of each frame
- seg_n  out  7  active-low segments; bit 0 = a … bit 6 = g
- dp_n  out  1  active-low decimal point
- an_n  out  NUM_DIGITS  active-low anodes; bit k = digit k

## Operation
- Shadow registers hold data, enable mask and brightness. They reset to all-zero, so the display stays dark until the first update.
- update_req sets a pending flag. Several requests before one boundary collapse into a single load and a single ack.
- The load happens in the frame-boundary cycle, which is the last cycle of the digit NUM_DIGITS-1 slot. A request seen in that same cycle is accepted at that boundary. update_ack pulses in that cycle and pending clears.
- Slot FSM, one slot per digit, in the order 0, 1, … NUM_DIGITS-1, then wrap to 0:
  - BLANK: lasts BLANK_TICKS cycles. All anodes off, seg_n and dp_n all 1.
  - ON: lasts ON_TICKS = DIGIT_TICKS-BLANK_TICKS cycles, split into 16 slices of ON_TICKS/16 cycles each.
  - In ON, the anode of the current digit is low while slice index <= brightness and the digit is enabled.
  - In ON, seg_n and dp_n show the digit pattern whenever the digit is enabled, regardless of the PWM phase.
  - ON goes to BLANK of the next digit.
- A disabled digit keeps its full slot time with its anode off, so the frame period stays NUM_DIGITS*DIGIT_TICKS.
- The slot counter width is clog2(DIGIT_TICKS). The counter wraps only at the slot end, never by overflow.

## Timing
- Reset values: an_n all 1, seg_n 7'h7F, dp_n 1, update_ack 0, frame_tick 0. Internal state is BLANK, digit 0, counter 0, pending 0, shadows 0.
- ARESET asserted mid-operation forces all outputs to their reset values asynchronously. A pending request is discarded and no ack is issued.
- All outputs are registered. an_n, seg_n and dp_n change 1 cycle after the FSM state or counter that selects them.
- frame_tick and update_ack are registered pulses aligned to the same boundary cycle.
- The new shadow contents first appear at the first ON cycle of digit 0 in the next frame.
- After reset release, the first frame_tick occurs NUM_DIGITS*DIGIT_TICKS cycles later.

## Configuration
- SEG7_DECODE_EN defined:
  - bits 3:0 of each digit byte are a hex nibble, decoded to standard 0–F patterns. Examples: 0 → seg_n 7'b1000000, 1 → 7'b1111001, 8 → 7'b0000000, F → 7'b0001110.
  - bits 6:4 are ignored.
- SEG7_DECODE_EN undefined:
  - bits 6:0 are raw active-high segment enables, with bit 0 = a.
  - seg_n is the bitwise inverse of bits 6:0.

## Test plan
All scenarios use NUM_DIGITS=4, DIGIT_TICKS=36, BLANK_TICKS=4, giving ON_TICKS=32, slice length 2 and frame length 144.

- Reset, then no update for 300 cycles -> an_n stays 4'hF, seg_n stays 7'h7F, dp_n stays 1, frame_tick pulses at cycles 144 and 288.
- SEG7_DECODE_EN defined; digit_data = {8'h00, 8'h80, 8'h01, 8'h08}, digit_en 4'hF, brightness 15, update_req pulsed mid-frame ->
  - update_ack pulses coincident with frame_tick.
  - In the next frame, an_n cycles E, D, B, 7; each is low for 32 cycles after a 4-cycle blank.
  - seg_n shows 7'h00, 7'h79, 7'h40, 7'h40; dp_n is low only for digit 2.
- brightness 3 loaded -> each anode low for exactly 8 cycles, starting at the first ON cycle; seg_n stays valid for all 32 ON cycles.
- digit_en 4'b0101 loaded -> an_n[1] and an_n[3] never go low; frame_tick period stays 144.
- update_req three times in one frame, plus one update_req in the boundary cycle of another frame -> exactly one update_ack per frame, each at that frame's boundary.
- ARESET asserted at ON cycle 10 of digit 2 with an update pending -> outputs reach reset values in the same cycle, and no update_ack follows after release.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seg7_scan_ctrl : multiplexed 7-segment refresh with blanking, PWM and     |
// |                  frame-synchronous double-buffered register updates.      |
// | Optional: SEG7_DECODE_EN selects hex-nibble decode instead of raw bits.   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module seg7_scan_ctrl #(
   parameter int NUM_DIGITS  = 4,
   parameter int DIGIT_TICKS = 100016,
   parameter int BLANK_TICKS = 16
) (
   input  logic                    ACLK,
   input  logic                    ARESET,
   input  logic [8*NUM_DIGITS-1:0] digit_data,
   input  logic [NUM_DIGITS-1:0]   digit_en,
   input  logic [3:0]              brightness,
   input  logic                    update_req,
   output logic                    update_ack,
   output logic                    frame_tick,
   output logic [6:0]              seg_n,
   output logic                    dp_n,
   output logic [NUM_DIGITS-1:0]   an_n
);

   localparam int ON_TICKS    = DIGIT_TICKS - BLANK_TICKS;
   localparam int SLICE_TICKS = ON_TICKS / 16;
   localparam int CNT_W       = $clog2(DIGIT_TICKS);
   localparam int DIG_W       = $clog2(NUM_DIGITS);
   localparam int SLC_W       = (SLICE_TICKS > 1) ? $clog2(SLICE_TICKS) : 1;

   typedef enum logic [0:0] {
      ST_BLANK = 1'b0,
      ST_ON    = 1'b1
   } state_t;

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [DIG_W-1:0]        digit_q, digit_d;
   logic [SLC_W-1:0]        slc_cnt_q, slc_cnt_d;
   logic [3:0]              slc_idx_q, slc_idx_d;
   logic                    pend_q, pend_d;
   logic                    ack_q, ack_d;
   logic                    tick_q, tick_d;
   logic [8*NUM_DIGITS-1:0] data_sh_q, data_sh_d;
   logic [NUM_DIGITS-1:0]   en_sh_q, en_sh_d;
   logic [3:0]              bright_sh_q, bright_sh_d;
   logic [NUM_DIGITS-1:0]   an_n_q, an_n_d;
   logic [6:0]              seg_n_q, seg_n_d;
   logic                    dp_n_q, dp_n_d;

   logic                    slot_end;
   logic                    boundary;
   logic [7:0]              cur_byte;

   function automatic logic [6:0] seg_pattern(input logic [6:0] b);
`ifdef SEG7_DECODE_EN
      case (b[3:0])
         4'h0: return 7'b1000000;
         4'h1: return 7'b1111001;
         4'h2: return 7'b0100100;
         4'h3: return 7'b0110000;
         4'h4: return 7'b0011001;
         4'h5: return 7'b0010010;
         4'h6: return 7'b0000010;
         4'h7: return 7'b1111000;
         4'h8: return 7'b0000000;
         4'h9: return 7'b0010000;
         4'hA: return 7'b0001000;
         4'hB: return 7'b0000011;
         4'hC: return 7'b1000110;
         4'hD: return 7'b0100001;
         4'hE: return 7'b0000110;
         default: return 7'b0001110;
      endcase
`else
      return ~b;
`endif
   endfunction

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q + CNT_W'(1);
      digit_d     = digit_q;
      slc_cnt_d   = slc_cnt_q;
      slc_idx_d   = slc_idx_q;
      pend_d      = pend_q | update_req;
      data_sh_d   = data_sh_q;
      en_sh_d     = en_sh_q;
      bright_sh_d = bright_sh_q;
      an_n_d      = '1;
      seg_n_d     = '1;
      dp_n_d      = 1'b1;

      slot_end = (cnt_q == CNT_W'(DIGIT_TICKS - 1));
      boundary = slot_end && (digit_q == DIG_W'(NUM_DIGITS - 1));

      case (state_q)
         ST_BLANK: begin
            if (cnt_q == CNT_W'(BLANK_TICKS - 1)) begin
               state_d   = ST_ON;
               slc_cnt_d = '0;
               slc_idx_d = '0;
            end
         end
         default: begin
            if (slc_cnt_q == SLC_W'(SLICE_TICKS - 1)) begin
               slc_cnt_d = '0;
               slc_idx_d = slc_idx_q + 4'd1;
            end else begin
               slc_cnt_d = slc_cnt_q + SLC_W'(1);
            end
            if (slot_end) begin
               state_d = ST_BLANK;
               cnt_d   = '0;
               digit_d = boundary ? '0 : digit_q + DIG_W'(1);
            end
         end
      endcase

      // A request arriving in the boundary cycle itself is folded into this load.
      ack_d  = boundary && (pend_q || update_req);
      tick_d = boundary;
      if (boundary) begin
         pend_d = 1'b0;
      end
      if (ack_d) begin
         data_sh_d   = digit_data;
         en_sh_d     = digit_en;
         bright_sh_d = brightness;
      end

      cur_byte = data_sh_q[digit_q*8 +: 8];
      if ((state_q == ST_ON) && en_sh_q[digit_q]) begin
         seg_n_d = seg_pattern(cur_byte[6:0]);
         dp_n_d  = ~cur_byte[7];
         if (slc_idx_q <= bright_sh_q) begin
            an_n_d[digit_q] = 1'b0;
         end
      end
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state_q     <= ST_BLANK;
         cnt_q       <= '0;
         digit_q     <= '0;
         slc_cnt_q   <= '0;
         slc_idx_q   <= '0;
         pend_q      <= 1'b0;
         ack_q       <= 1'b0;
         tick_q      <= 1'b0;
         data_sh_q   <= '0;
         en_sh_q     <= '0;
         bright_sh_q <= '0;
         an_n_q      <= '1;
         seg_n_q     <= '1;
         dp_n_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         digit_q     <= digit_d;
         slc_cnt_q   <= slc_cnt_d;
         slc_idx_q   <= slc_idx_d;
         pend_q      <= pend_d;
         ack_q       <= ack_d;
         tick_q      <= tick_d;
         data_sh_q   <= data_sh_d;
         en_sh_q     <= en_sh_d;
         bright_sh_q <= bright_sh_d;
         an_n_q      <= an_n_d;
         seg_n_q     <= seg_n_d;
         dp_n_q      <= dp_n_d;
      end
   end

   assign update_ack = ack_q;
   assign frame_tick = tick_q;
   assign an_n       = an_n_q;
   assign seg_n      = seg_n_q;
   assign dp_n       = dp_n_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
`default_nettype none
// Testbench for seg7_scan_ctrl: 4 digits, 36-cycle slots, 4-cycle blank.
module tb_seg7_scan_ctrl;

   localparam int ND    = 4;
   localparam int DT    = 36;
   localparam int BT    = 4;
   localparam int FRAME = ND * DT;

   logic          ACLK = 1'b0;
   logic          ARESET = 1'b1;
   logic [31:0]   digit_data = '0;
   logic [3:0]    digit_en = '0;
   logic [3:0]    brightness = '0;
   logic          update_req = 1'b0;
   logic          update_ack;
   logic          frame_tick;
   logic [6:0]    seg_n;
   logic          dp_n;
   logic [3:0]    an_n;

   int n_checks = 0;
   int n_errors = 0;

   seg7_scan_ctrl #(.NUM_DIGITS(ND), .DIGIT_TICKS(DT), .BLANK_TICKS(BT)) dut (
      .ACLK(ACLK), .ARESET(ARESET), .digit_data(digit_data), .digit_en(digit_en),
      .brightness(brightness), .update_req(update_req), .update_ack(update_ack),
      .frame_tick(frame_tick), .seg_n(seg_n), .dp_n(dp_n), .an_n(an_n)
   );

   always #5 ACLK = ~ACLK;

   typedef struct {
      logic [31:0]      data;
      logic [3:0]       en;
      logic [3:0]       bright;
      logic [3:0][6:0]  seg;
      logic [3:0]       dpn;
   } vec_t;

   vec_t vecs[4];

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drives update_req high after sample s for each listed offset; reports acks.
   task automatic run_frame(input int ra, input int rb, input int rc,
                            output int acks, output int ack_last_ok);
      acks = 0;
      ack_last_ok = 0;
      for (int s = 0; s < FRAME; s++) begin
         tick();
         if (update_ack) begin
            acks++;
            if (s == FRAME - 1 && frame_tick) ack_last_ok = 1;
         end
         update_req = (s == ra || s == rb || s == rc);
      end
      update_req = 1'b0;
   endtask

   initial begin
      int acks, ok, found, bad, first_ft;
      logic [3:0] an_e;
      logic [6:0] seg_e;
      logic       dp_e;

      vecs[0].data = {8'h00, 8'h80, 8'h01, 8'h08}; vecs[0].en = 4'hF; vecs[0].bright = 4'd15;
      vecs[1].data = {8'h3F, 8'h06, 8'h5B, 8'h4F}; vecs[1].en = 4'hF; vecs[1].bright = 4'd3;
      vecs[2].data = {8'h81, 8'h82, 8'h84, 8'h88}; vecs[2].en = 4'b0101; vecs[2].bright = 4'd7;
      vecs[3].data = {8'h40, 8'h20, 8'h10, 8'h01}; vecs[3].en = 4'hF; vecs[3].bright = 4'd0;
`ifdef SEG7_DECODE_EN
      vecs[0].seg = {7'h40, 7'h40, 7'h79, 7'h00};
      vecs[1].seg = {7'h0E, 7'h02, 7'h03, 7'h0E};
      vecs[2].seg = {7'h7F, 7'h24, 7'h7F, 7'h00};
      vecs[3].seg = {7'h40, 7'h40, 7'h40, 7'h79};
`else
      vecs[0].seg = {7'h7F, 7'h7F, 7'h7E, 7'h77};
      vecs[1].seg = {7'h40, 7'h79, 7'h24, 7'h30};
      vecs[2].seg = {7'h7F, 7'h7D, 7'h7F, 7'h77};
      vecs[3].seg = {7'h3F, 7'h5F, 7'h6F, 7'h7E};
`endif
      vecs[0].dpn = 4'b1011;
      vecs[1].dpn = 4'b1111;
      vecs[2].dpn = 4'b1010;
      vecs[3].dpn = 4'b1111;

      // Reset state, then idle with empty shadows.
      repeat (3) tick();
      chk("reset_outputs", {an_n, seg_n, dp_n, update_ack, frame_tick}, {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0});
      ARESET = 1'b0;
      bad = 0;
      for (int c = 1; c <= 300; c++) begin
         tick();
         if ({an_n, seg_n, dp_n, update_ack} !== {4'hF, 7'h7F, 1'b1, 1'b0}) bad++;
         if (frame_tick !== (c == 144 || c == 288)) begin
            chk($sformatf("idle_frame_tick_c%0d", c), {31'd0, frame_tick}, {31'd0, (c == 144 || c == 288)});
         end else if (c == 144 || c == 288) begin
            chk($sformatf("idle_frame_tick_c%0d", c), {31'd0, frame_tick}, 32'd1);
         end
      end
      chk("idle_dark_cycles_bad", bad, 0);

      // Table-driven frames: load, wait for the boundary, compare the next frame cycle by cycle.
      for (int v = 0; v < 4; v++) begin
         repeat (20) tick();
         digit_data = vecs[v].data;
         digit_en   = vecs[v].en;
         brightness = vecs[v].bright;
         update_req = 1'b1;
         tick();
         update_req = 1'b0;
         found = 0;
         for (int w = 0; w < 2 * FRAME && found == 0; w++) begin
            if (update_ack) found = 1;
            else tick();
         end
         chk($sformatf("v%0d_ack_seen", v), found, 1);
         chk($sformatf("v%0d_ack_with_tick", v), {31'd0, frame_tick}, 32'd1);
         bad = 0;
         for (int s = 0; s < FRAME; s++) begin
            int d, off;
            tick();
            d = s / DT;
            off = s % DT;
            an_e = 4'hF; seg_e = 7'h7F; dp_e = 1'b1;
            if (off >= BT && vecs[v].en[d]) begin
               seg_e = vecs[v].seg[d];
               dp_e  = vecs[v].dpn[d];
               if ((off - BT) / 2 <= int'(vecs[v].bright)) an_e[d] = 1'b0;
            end
            if ({an_n, seg_n, dp_n, frame_tick, update_ack} !==
                {an_e, seg_e, dp_e, (s == FRAME - 1), 1'b0}) begin
               bad++;
               chk($sformatf("v%0d_s%0d", v, s), {18'd0, an_n, seg_n, dp_n, frame_tick, update_ack},
                   {18'd0, an_e, seg_e, dp_e, (s == FRAME - 1), 1'b0});
            end
         end
         chk($sformatf("v%0d_frame_bad_cycles", v), bad, 0);
      end

      // Three requests in one frame collapse into one ack at its boundary.
      digit_data = vecs[0].data; digit_en = vecs[0].en; brightness = vecs[0].bright;
      run_frame(10, 50, 100, acks, ok);
      chk("multi_req_acks", acks, 1);
      chk("multi_req_ack_at_boundary", ok, 1);
      // Request placed in the boundary cycle itself is accepted there.
      run_frame(FRAME - 2, -1, -1, acks, ok);
      chk("boundary_req_acks", acks, 1);
      chk("boundary_req_ack_at_boundary", ok, 1);
      run_frame(-1, -1, -1, acks, ok);
      chk("no_req_acks", acks, 0);

      // Reset at ON cycle 10 of digit 2 with a request pending.
      for (int s = 0; s <= 2 * DT + BT + 10; s++) begin
         tick();
         update_req = (s == 20);
      end
      update_req = 1'b0;
      chk("pre_reset_an", {28'd0, an_n}, 32'hB);
      ARESET = 1'b1;
      #1;
      chk("async_reset_outputs", {an_n, seg_n, dp_n, update_ack, frame_tick}, {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0});
      repeat (3) tick();
      ARESET = 1'b0;
      acks = 0; bad = 0; first_ft = 0;
      for (int c = 1; c <= 300; c++) begin
         tick();
         if (update_ack) acks++;
         if (an_n !== 4'hF) bad++;
         if (frame_tick && first_ft == 0) first_ft = c;
      end
      chk("post_reset_no_ack", acks, 0);
      chk("post_reset_dark", bad, 0);
      chk("post_reset_first_tick", first_ft, FRAME);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
